// File: rtl/manual_state_executor.sv
// Sequential back end of manual drive: power sequencing, run-state registers, wheel map, turn LEDs, mileage.
// Latency: state/moving_state 1 cycle after next_* inputs, wheels and LEDs 1 cycle later; no backpressure.
module manual_state_executor #(
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int BLINK_DIV   = 50_000_000,
  parameter int MILE_TICK   = 100_000_000,
  parameter int MILE_W      = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              power_in,
  input  logic              mode_manual,
  input  logic [1:0]        next_state,
  input  logic [3:0]        next_moving_state,
  input  logic              manual_power,
  input  logic              turn_left_req,
  input  logic              turn_right_req,
  output logic              power,
  output logic [1:0]        state,
  output logic [3:0]        moving_state,
  output logic              wheel_l_en,
  output logic              wheel_l_fwd,
  output logic              wheel_r_en,
  output logic              wheel_r_fwd,
  output logic              turn_left_led,
  output logic              turn_right_led,
  output logic              stall_pulse,
  output logic [MILE_W-1:0] mileage
);

  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int TICK_W  = (MILE_TICK > 1) ? $clog2(MILE_TICK) : 1;

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(MILE_TICK - 1);

  localparam logic [1:0] ST_NSTART = 2'b00;
  localparam logic [1:0] ST_MOVING = 2'b10;

  typedef enum logic {PWR_OFF, PWR_ON} pwr_t;

  pwr_t               pwr_q, pwr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               going_off, entering_on, stall_d;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [TICK_W-1:0]  tick_cnt;
  logic               legal;

  assign power = (pwr_q == PWR_ON);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwr_q  <= PWR_OFF;
      hold_q <= '0;
    end else begin
      pwr_q  <= pwr_d;
      hold_q <= hold_d;
    end
  end

  // Hold counter only runs while OFF with the switch held; any low cycle restarts it.
  always_comb begin
    pwr_d       = pwr_q;
    hold_d      = '0;
    going_off   = 1'b0;
    entering_on = 1'b0;
    stall_d     = 1'b0;
    case (pwr_q)
      PWR_OFF: begin
        if (power_in) begin
          if (hold_q == HOLD_LAST) begin
            pwr_d       = PWR_ON;
            entering_on = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      PWR_ON: begin
        stall_d = mode_manual & ~manual_power;
        if (!power_in || stall_d) begin
          pwr_d     = PWR_OFF;
          going_off = 1'b1;
        end
      end
      default: pwr_d = PWR_OFF;
    endcase
  end

  assign legal = (next_state != 2'b11) &&
                 ((next_moving_state & (next_moving_state - 4'd1)) == 4'd0);

  // Run state drops to NSTART on the same edge that power goes off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_NSTART;
      moving_state <= 4'b0000;
      stall_pulse  <= 1'b0;
    end else begin
      stall_pulse <= stall_d;
      if (pwr_q == PWR_OFF || going_off) begin
        state        <= ST_NSTART;
        moving_state <= 4'b0000;
      end else if (mode_manual) begin
        if (!legal) begin
          state        <= ST_NSTART;
          moving_state <= 4'b0000;
        end else begin
          state        <= next_state;
          moving_state <= (next_state == ST_MOVING) ? next_moving_state : 4'b0000;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {wheel_l_en, wheel_l_fwd, wheel_r_en, wheel_r_fwd} <= 4'b0000;
    end else begin
      case (moving_state)
        4'b0001: {wheel_l_en, wheel_l_fwd, wheel_r_en, wheel_r_fwd} <= 4'b1111;
        4'b0010: {wheel_l_en, wheel_l_fwd, wheel_r_en, wheel_r_fwd} <= 4'b1010;
        4'b0100: {wheel_l_en, wheel_l_fwd, wheel_r_en, wheel_r_fwd} <= 4'b0011;
        4'b1000: {wheel_l_en, wheel_l_fwd, wheel_r_en, wheel_r_fwd} <= 4'b1100;
        default: {wheel_l_en, wheel_l_fwd, wheel_r_en, wheel_r_fwd} <= 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt      <= '0;
      blink_phase    <= 1'b0;
      turn_left_led  <= 1'b0;
      turn_right_led <= 1'b0;
    end else begin
      if (entering_on) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (pwr_q == PWR_ON) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
      turn_left_led  <= power & ~going_off & turn_left_req  & blink_phase;
      turn_right_led <= power & ~going_off & turn_right_req & blink_phase;
    end
  end

  // Mileage survives power-off; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      mileage  <= '0;
    end else if (state == ST_MOVING && moving_state != 4'b0000) begin
      if (tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
        if (mileage != {MILE_W{1'b1}}) mileage <= mileage + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

endmodule
